// File: rtl/root_job_scheduler_pkg.sv
// Shared types and widths for the root job scheduler.
//   RADICAND_W / DEGREE_W / RESULT_W : engine operand and result widths
//   state_t                          : scheduler FSM states
package root_sched_pkg;

    localparam int RADICAND_W = 10;
    localparam int DEGREE_W   = 3;
    localparam int RESULT_W   = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_QUIET,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/root_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority requester index for this decision
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : encoded index of the granted requester
//   any_req   : at least one request present
module rr_arbiter
    import root_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    // First pass searches ptr..NUM_REQ-1, second pass wraps to 0..ptr-1;
    // the second pass only acts when the first one found nothing.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_req && req[i] && (i >= 32'(ptr))) begin
                any_req   = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_req && req[i]) begin
                any_req   = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/root_job_scheduler.sv
// Shares one iterative root engine between NUM_REQ requesters.
// Round-robin arbitration, one job in flight, engine operands held stable for
// the whole computation, per-job watchdog, tagged responses on one port.
//   clk, rst_n         : clock, synchronous active-low reset
//   req_valid/ready    : per-requester handshake (ready is a one-hot pulse)
//   req_radicand/degree: packed per-requester operands (slice i = requester i)
//   rsp_valid/ready    : response handshake
//   rsp_id/data/err    : response tag, result (0 on error), error flag
//   eng_in_valid       : one-cycle engine start strobe
//   eng_in_data_1/2    : engine radicand / degree, held between jobs
//   eng_out_valid/data : engine completion and result
module root_job_scheduler
    import root_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*RADICAND_W-1:0] req_radicand,
    input  logic [NUM_REQ*DEGREE_W-1:0]   req_degree,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [RESULT_W-1:0]           rsp_data,
    output logic                          rsp_err,
    output logic                          eng_in_valid,
    output logic [RADICAND_W-1:0]         eng_in_data_1,
    output logic [DEGREE_W-1:0]           eng_in_data_2,
    input  logic                          eng_out_valid,
    input  logic [RESULT_W-1:0]           eng_out_data
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state, state_nxt;
    logic [ID_W-1:0]         rr_ptr;
    logic                    drain_flag;
    logic [WD_W-1:0]         wd_cnt;
    logic                    wd_expired;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [ID_W-1:0]         arb_idx;
    logic                    arb_any;
    logic                    start;
    logic [RADICAND_W-1:0]   sel_rad;
    logic [DEGREE_W-1:0]     sel_deg;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    // A grant is only made while the engine is not still presenting a result.
    assign start      = (state == S_IDLE) && arb_any && !eng_out_valid;
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES));

    always_comb begin
        sel_rad = '0;
        sel_deg = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == ID_W'(i)) begin
                sel_rad = req_radicand[i*RADICAND_W +: RADICAND_W];
                sel_deg = req_degree[i*DEGREE_W +: DEGREE_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (sel_deg == '0) ? S_RESP : S_ISSUE;
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (eng_out_valid || wd_expired) state_nxt = S_RESP;
            end
            S_RESP: begin
                // A late pulse already seen while responding counts as drained.
                if (rsp_ready)
                    state_nxt = (drain_flag && !eng_out_valid) ? S_DRAIN : S_QUIET;
            end
            S_QUIET: begin
                if (!eng_out_valid) state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (eng_out_valid || wd_expired) state_nxt = S_QUIET;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready    = '0;
        eng_in_valid = (state == S_ISSUE);
        rsp_valid    = (state == S_RESP);
        if (start && rst_n) req_ready = arb_grant;
    end

    // Watchdog runs only while waiting on the engine; zero everywhere else.
    always_ff @(posedge clk) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state == S_WAIT || state == S_DRAIN)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end

    // Job latches, engine operands, response register, RR pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            drain_flag    <= 1'b0;
            eng_in_data_1 <= '0;
            eng_in_data_2 <= '0;
            rsp_id        <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rr_ptr     <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        rsp_id     <= arb_idx;
                        drain_flag <= 1'b0;
                        if (sel_deg == '0) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end else begin
                            eng_in_data_1 <= sel_rad;
                            eng_in_data_2 <= sel_deg;
                        end
                    end
                end
                S_WAIT: begin
                    if (eng_out_valid) begin
                        rsp_data <= eng_out_data;
                        rsp_err  <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        drain_flag <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (drain_flag && eng_out_valid) drain_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_root_job_scheduler.sv
module tb_root_job_scheduler;
    import root_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = 2;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*RADICAND_W-1:0] req_radicand;
    logic [NUM_REQ*DEGREE_W-1:0]   req_degree;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [RESULT_W-1:0]           rsp_data;
    logic                          rsp_err;
    logic                          eng_in_valid;
    logic [RADICAND_W-1:0]         eng_in_data_1;
    logic [DEGREE_W-1:0]           eng_in_data_2;
    logic                          eng_out_valid;
    logic [RESULT_W-1:0]           eng_out_data;

    root_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ID_W           (ID_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_radicand  (req_radicand),
        .req_degree    (req_degree),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .eng_in_valid  (eng_in_valid),
        .eng_in_data_1 (eng_in_data_1),
        .eng_in_data_2 (eng_in_data_2),
        .eng_out_valid (eng_out_valid),
        .eng_out_data  (eng_out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Engine model knobs: latency (-1 = never answers), out_valid hold length
    int mdl_lat       = 1;
    int mdl_hold      = 1;
    int mdl_issues    = 0;
    int mdl_late_req  = 0;
    int mdl_late_done = 0;
    logic                  mdl_busy;
    int                    mdl_cnt;
    int                    mdl_hold_left;
    logic [RADICAND_W-1:0] mdl_rad;
    logic [DEGREE_W-1:0]   mdl_deg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Integer root: largest r with r**deg <= rad
    function automatic logic [RESULT_W-1:0] iroot(input logic [9:0] rad, input logic [2:0] deg);
        int r;
        longint p;
        r = 0;
        for (int c = 1; c <= 1023; c++) begin
            p = 1;
            for (int k = 0; k < int'(deg); k++) p = p * c;
            if (p <= longint'(rad)) r = c;
            else break;
        end
        return RESULT_W'(r);
    endfunction

    // Behavioural engine, acts on the falling edge
    initial begin
        eng_out_valid = 1'b0;
        eng_out_data  = '0;
        mdl_busy      = 1'b0;
        mdl_cnt       = 0;
        mdl_hold_left = 0;
        mdl_rad       = '0;
        mdl_deg       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eng_out_valid = 1'b0;
                eng_out_data  = '0;
                mdl_busy      = 1'b0;
                mdl_hold_left = 0;
            end else begin
                if (eng_out_valid) begin
                    if (mdl_hold_left > 1) mdl_hold_left--;
                    else begin
                        eng_out_valid = 1'b0;
                        mdl_hold_left = 0;
                    end
                end
                if (mdl_late_req != mdl_late_done) begin
                    mdl_late_done++;
                    mdl_busy      = 1'b0;
                    eng_out_valid = 1'b1;
                    eng_out_data  = 20'hABCDE;
                    mdl_hold_left = 1;
                end else if (eng_in_valid) begin
                    check("one_in_flight", {31'b0, mdl_busy | eng_out_valid}, 32'd0);
                    mdl_issues++;
                    mdl_busy = 1'b1;
                    mdl_cnt  = mdl_lat;
                    mdl_rad  = eng_in_data_1;
                    mdl_deg  = eng_in_data_2;
                end else if (mdl_busy) begin
                    check("eng_operands_held", {19'b0, eng_in_data_1, eng_in_data_2}, {19'b0, mdl_rad, mdl_deg});
                    if (mdl_lat >= 0) begin
                        if (mdl_cnt == 0) begin
                            eng_out_valid = 1'b1;
                            eng_out_data  = iroot(mdl_rad, mdl_deg);
                            mdl_hold_left = mdl_hold;
                            mdl_busy      = 1'b0;
                        end else begin
                            mdl_cnt--;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int r, input logic [9:0] rad, input logic [2:0] deg);
        req_radicand[r*RADICAND_W +: RADICAND_W] = rad;
        req_degree[r*DEGREE_W +: DEGREE_W]       = deg;
    endtask

    task automatic wait_ready(output int g);
        int n;
        n = 0;
        g = -1;
        #1;
        while (req_ready == '0 && n < 100) begin
            cyc();
            #1;
            n++;
        end
        check("grant_within_bound", {31'b0, n < 100}, 32'd1);
        check("ready_onehot", $countones(req_ready), 32'd1);
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            cyc();
            n++;
        end
        check("rsp_within_bound", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("rsp_cleared", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int g, n, q, issues_before;
        logic [RESULT_W-1:0] exp2 [NUM_REQ];
        exp2 = '{20'd4, 20'd3, 20'd31, 20'd2};

        rst_n        = 1'b0;
        req_valid    = '0;
        req_radicand = '0;
        req_degree   = '0;
        rsp_ready    = 1'b0;
        repeat (3) cyc();
        check("rst_outputs", {24'b0, req_ready, rsp_valid, eng_in_valid, rsp_err, rsp_id},  32'd0);
        check("rst_eng_data", {19'b0, eng_in_data_1, eng_in_data_2}, 32'd0);
        check("rst_rsp_data", {12'b0, rsp_data}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // 1: single job, radicand 16 degree 2
        mdl_lat = 2; mdl_hold = 1;
        set_job(0, 10'd16, 3'd2);
        req_valid = 4'b0001;
        wait_ready(g);
        check("t1_grant", g, 32'd0);
        cyc();
        req_valid = '0;
        #1;
        check("t1_ready_pulse", {28'b0, req_ready}, 32'd0);
        check("t1_issue", {31'b0, eng_in_valid}, 32'd1);
        check("t1_issue_data", {19'b0, eng_in_data_1, eng_in_data_2}, {19'b0, 10'd16, 3'd2});
        cyc();
        check("t1_issue_once", {31'b0, eng_in_valid}, 32'd0);
        check("t1_data_held", {22'b0, eng_in_data_1}, 32'd16);
        wait_rsp(n);
        check("t1_latency", n, 32'd3);
        check("t1_rsp", {9'b0, rsp_id, rsp_err, rsp_data}, {9'b0, 2'd0, 1'b0, 20'd4});
        handshake();

        // 2: all requesters held -> 0,1,2,3,0 from a fresh pointer
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        mdl_lat = 1; mdl_hold = 1;
        set_job(0, 10'd16, 3'd2);
        set_job(1, 10'd27, 3'd3);
        set_job(2, 10'd1023, 3'd2);
        set_job(3, 10'd255, 3'd7);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ready(g);
            check("t2_grant_order", g, k % NUM_REQ);
            cyc();
            if (k == 4) req_valid = '0;
            wait_rsp(n);
            check("t2_rsp", {9'b0, rsp_id, rsp_err, rsp_data},
                  {9'b0, 2'(k % NUM_REQ), 1'b0, exp2[k % NUM_REQ]});
            handshake();
        end

        // 3: degree 0 rejected without touching the engine
        issues_before = mdl_issues;
        set_job(2, 10'd5, 3'd0);
        req_valid = 4'b0100;
        wait_ready(g);
        check("t3_grant", g, 32'd2);
        cyc();
        req_valid = '0;
        check("t3_rsp", {8'b0, rsp_valid, rsp_id, rsp_err, rsp_data}, {8'b0, 1'b1, 2'd2, 1'b1, 20'd0});
        check("t3_no_issue", {31'b0, eng_in_valid}, 32'd0);
        handshake();
        cyc();
        check("t3_issue_count", mdl_issues, issues_before);

        // 4: engine never answers -> timeout, late pulse drained
        mdl_lat = -1;
        set_job(3, 10'd100, 3'd2);
        req_valid = 4'b1000;
        wait_ready(g);
        check("t4_grant", g, 32'd3);
        cyc();
        req_valid = '0;
        wait_rsp(n);
        check("t4_timeout_time", n, TIMEOUT + 2);
        check("t4_rsp", {9'b0, rsp_id, rsp_err, rsp_data}, {9'b0, 2'd3, 1'b1, 20'd0});
        handshake();
        set_job(1, 10'd1000, 3'd3);
        req_valid = 4'b0010;
        repeat (3) begin
            #1;
            check("t4_drain_no_grant", {28'b0, req_ready}, 32'd0);
            cyc();
        end
        mdl_lat = 3;
        mdl_late_req++;
        wait_ready(g);
        check("t4_next_grant", g, 32'd1);
        cyc();
        req_valid = '0;
        wait_rsp(n);
        check("t4_next_rsp", {9'b0, rsp_id, rsp_err, rsp_data}, {9'b0, 2'd1, 1'b0, 20'd10});
        handshake();

        // 5a: consumer stalls 10 cycles
        mdl_lat = 2; mdl_hold = 1;
        set_job(0, 10'd100, 3'd2);
        req_valid = 4'b0001;
        wait_ready(g);
        check("t5_grant", g, 32'd0);
        cyc();
        req_valid = '0;
        wait_rsp(n);
        set_job(1, 10'd27, 3'd3);
        req_valid = 4'b0010;
        mdl_lat = 0; mdl_hold = 6;
        repeat (10) begin
            #1;
            check("t5_stall", {4'b0, rsp_valid, rsp_err, rsp_id, rsp_data, req_ready},
                  {4'b0, 1'b1, 1'b0, 2'd0, 20'd10, 4'b0000});
            cyc();
        end
        handshake();

        // 5b: engine holds out_valid several cycles -> no early reissue
        wait_ready(g);
        check("t5b_grant", g, 32'd1);
        cyc();
        set_job(2, 10'd1023, 3'd2);
        req_valid = 4'b0100;
        wait_rsp(n);
        check("t5b_rsp", {9'b0, rsp_id, rsp_err, rsp_data}, {9'b0, 2'd1, 1'b0, 20'd3});
        mdl_hold = 1; mdl_lat = 1;
        handshake();
        q = 0;
        while (eng_out_valid && q < 20) begin
            #1;
            check("t5b_quiet", {30'b0, eng_in_valid, |req_ready}, 32'd0);
            cyc();
            q++;
        end
        check("t5b_hold_seen", {31'b0, q > 0 && q < 20}, 32'd1);
        wait_ready(g);
        check("t5b_next_grant", g, 32'd2);
        cyc();
        req_valid = '0;
        wait_rsp(n);
        check("t5b_next_rsp", {9'b0, rsp_id, rsp_err, rsp_data}, {9'b0, 2'd2, 1'b0, 20'd31});
        handshake();

        // 6: reset during WAIT aborts the job
        mdl_lat = -1;
        set_job(3, 10'd81, 3'd4);
        req_valid = 4'b1000;
        wait_ready(g);
        check("t6_grant", g, 32'd3);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        check("t6_waiting", {22'b0, eng_in_data_1}, 32'd81);
        rst_n = 1'b0;
        cyc();
        check("t6_rst_outputs", {24'b0, req_ready, rsp_valid, eng_in_valid, rsp_err, rsp_id}, 32'd0);
        check("t6_rst_eng_data", {19'b0, eng_in_data_1, eng_in_data_2}, 32'd0);
        check("t6_rst_rsp_data", {12'b0, rsp_data}, 32'd0);
        rst_n = 1'b1;
        mdl_lat = 1;
        cyc();
        check("t6_no_stale_rsp", {31'b0, rsp_valid}, 32'd0);
        set_job(0, 10'd1000, 3'd3);
        req_valid = 4'b1001;
        wait_ready(g);
        check("t6_ptr_reset_grant", g, 32'd0);
        cyc();
        req_valid = 4'b1000;
        wait_rsp(n);
        check("t6_rsp0", {9'b0, rsp_id, rsp_err, rsp_data}, {9'b0, 2'd0, 1'b0, 20'd10});
        handshake();
        wait_ready(g);
        check("t6_grant3", g, 32'd3);
        cyc();
        req_valid = '0;
        wait_rsp(n);
        check("t6_rsp3", {9'b0, rsp_id, rsp_err, rsp_data}, {9'b0, 2'd3, 1'b0, 20'd3});
        handshake();

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
